pipelined_processor: RTL and testbench

PIPELINED_PROCESSOR -- requirements
Module: pipelined_processor

---
 rtl/pipelined_processor_pkg.sv | 114 +++++++++++
 rtl/pp_alu.sv | 23 ++
 rtl/pipelined_processor.sv | 175 +++++++++++++++++
 tb/tb_pipelined_processor.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_processor_pkg.sv
// Shared constants, instruction field positions and pipeline-register types
// for the 5-stage pipelined processor.
package pipelined_processor_pkg;

    localparam int unsigned DataW    = 16;
    localparam int unsigned AddrW    = 10;
    localparam int unsigned MemDepth = 1024;
    localparam int unsigned NumRegs  = 8;

    // Instruction fields: op[15:11], Rs[10:8], Rd[7:5], [4:0] ignored
    localparam int unsigned OpMsb = 15;
    localparam int unsigned OpLsb = 11;
    localparam int unsigned RsMsb = 10;
    localparam int unsigned RsLsb = 8;
    localparam int unsigned RdMsb = 7;
    localparam int unsigned RdLsb = 5;

    localparam logic [4:0] OpNop = 5'b00000;
    localparam logic [4:0] OpNot = 5'b00011;
    localparam logic [4:0] OpAdd = 5'b11001;
    localparam logic [4:0] OpStd = 5'b01100;
    localparam logic [4:0] OpLdd = 5'b01101;

    localparam logic [AddrW-1:0] ResetPc = 10'h020;

    typedef enum logic [2:0] {
        AluNop,
        AluNot,
        AluAdd,
        AluPassA,
        AluPassB
    } alu_op_e;

    typedef struct packed {
        logic [DataW-1:0] instr;
    } if_id_t;

    typedef struct packed {
        alu_op_e          alu_op;
        logic [2:0]       rs;
        logic [2:0]       rd;
        logic [DataW-1:0] rs_val;
        logic [DataW-1:0] rd_val;
        logic             reg_write;
        logic             mem_write;
        logic             mem_read;
    } id_ex_t;

    typedef struct packed {
        logic [2:0]       rd;
        logic [DataW-1:0] alu_y;
        logic [DataW-1:0] store_data;
        logic             reg_write;
        logic             mem_write;
        logic             mem_read;
    } ex_mem_t;

    typedef struct packed {
        logic [2:0]       rd;
        logic [DataW-1:0] wdata;
        logic             reg_write;
    } mem_wb_t;

    // All-zero encodings are bubbles: AluNop and no write strobes
    localparam if_id_t  IfIdNop  = '0;
    localparam id_ex_t  IdExNop  = '0;
    localparam ex_mem_t ExMemNop = '0;
    localparam mem_wb_t MemWbNop = '0;

    function automatic logic uses_rs(input logic [4:0] op);
        return (op == OpAdd) || (op == OpStd) || (op == OpLdd);
    endfunction

    function automatic logic uses_rd(input logic [4:0] op);
        return (op == OpNot) || (op == OpAdd) || (op == OpStd);
    endfunction

    // Memory ops route their address through the ALU: STD uses R[Rd], LDD uses R[Rs]
    function automatic id_ex_t decode(input logic [4:0]       op,
                                      input logic [2:0]       rs,
                                      input logic [2:0]       rd,
                                      input logic [DataW-1:0] rs_val,
                                      input logic [DataW-1:0] rd_val);
        id_ex_t d;
        d        = IdExNop;
        d.rs     = rs;
        d.rd     = rd;
        d.rs_val = rs_val;
        d.rd_val = rd_val;
        case (op)
            OpNot: begin
                d.alu_op    = AluNot;
                d.reg_write = 1'b1;
            end
            OpAdd: begin
                d.alu_op    = AluAdd;
                d.reg_write = 1'b1;
            end
            OpStd: begin
                d.alu_op    = AluPassB;
                d.mem_write = 1'b1;
            end
            OpLdd: begin
                d.alu_op    = AluPassA;
                d.reg_write = 1'b1;
                d.mem_read  = 1'b1;
            end
            OpNop:   ;
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pp_alu.sv
// EX-stage ALU: a is the Rs operand, b is the Rd operand.
module pp_alu
    import pipelined_processor_pkg::*;
(
    input  logic [2:0]       i_op,
    input  logic [DataW-1:0] i_a,
    input  logic [DataW-1:0] i_b,
    output logic [DataW-1:0] o_y
);

    // Result select; ADD carry out is dropped
    always_comb begin
        o_y = '0;
        case (i_op)
            AluNot:   o_y = ~i_b;
            AluAdd:   o_y = i_a + i_b;
            AluPassA: o_y = i_a;
            AluPassB: o_y = i_b;
            default:  o_y = '0;
        endcase
    end

endmodule

// File: rtl/pipelined_processor.sv
// 5-stage in-order pipeline (IF/ID/EX/MEM/WB) with separate instruction and
// data memories, EX operand forwarding and a one-cycle load-use stall.
module pipelined_processor
    import pipelined_processor_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  write_addr,
    output logic [15:0] result,
    input  logic        write_enable_fm,
    input  logic        rst_fm,
    input  logic [15:0] write_data_fm,
    input  logic [31:0] write_addr_fm,
    output logic [15:0] instruction,
    output logic        mem_write,
    output logic [15:0] show
);

    logic [DataW-1:0] r_imem [MemDepth];
    logic [DataW-1:0] r_dmem [MemDepth];
    logic [DataW-1:0] r_regs [NumRegs];

    logic [AddrW-1:0] r_pc;
    if_id_t           r_if_id;
    id_ex_t           r_id_ex;
    ex_mem_t          r_ex_mem;
    mem_wb_t          r_mem_wb;

    logic             w_load_en;
    logic [AddrW-1:0] w_load_addr;
    logic [AddrW-1:0] w_fetch_addr;
    logic             w_unused_load_addr_hi;
    logic             w_unused_instr_lo;

    logic [4:0]       w_id_op;
    logic [2:0]       w_id_rs;
    logic [2:0]       w_id_rd;
    logic [DataW-1:0] w_id_rs_val;
    logic [DataW-1:0] w_id_rd_val;
    logic             w_stall;

    logic [DataW-1:0] w_ex_a;
    logic [DataW-1:0] w_ex_b;
    logic [DataW-1:0] w_alu_y;

    logic [DataW-1:0] w_mem_result;
    logic             w_mem_write;

    // ---------------- IF ----------------
    assign w_load_en             = write_enable_fm && !rst_fm;
    assign w_load_addr           = write_addr_fm[AddrW-1:0];
    assign w_unused_load_addr_hi = ^write_addr_fm[31:AddrW];

    // Loader port; deliberately independent of core reset
    always_ff @(posedge clk) begin
        if (w_load_en) begin
            r_imem[w_load_addr] <= write_data_fm;
        end
    end

    // Fetch word, with loader write-through so a word being loaded is seen at once
    always_comb begin
        w_fetch_addr = reset ? ResetPc : r_pc;
        instruction  = r_imem[w_fetch_addr];
        if (w_load_en && (w_load_addr == w_fetch_addr)) begin
            instruction = write_data_fm;
        end
    end

    // ---------------- ID ----------------
    assign w_id_op           = r_if_id.instr[OpMsb:OpLsb];
    assign w_id_rs           = r_if_id.instr[RsMsb:RsLsb];
    assign w_id_rd           = r_if_id.instr[RdMsb:RdLsb];
    assign w_unused_instr_lo = ^r_if_id.instr[RdLsb-1:0];

    // Register read with WB write-through
    always_comb begin
        w_id_rs_val = r_regs[w_id_rs];
        w_id_rd_val = r_regs[w_id_rd];
        if (r_mem_wb.reg_write && (r_mem_wb.rd == w_id_rs)) begin
            w_id_rs_val = r_mem_wb.wdata;
        end
        if (r_mem_wb.reg_write && (r_mem_wb.rd == w_id_rd)) begin
            w_id_rd_val = r_mem_wb.wdata;
        end
    end

    // Load-use: the load's data only exists once it reaches MEM
    assign w_stall = r_id_ex.mem_read &&
                     ((uses_rs(w_id_op) && (w_id_rs == r_id_ex.rd)) ||
                      (uses_rd(w_id_op) && (w_id_rd == r_id_ex.rd)));

    // ---------------- EX ----------------
    // Operand forwarding; the younger producer (EX/MEM) wins over MEM/WB
    always_comb begin
        w_ex_a = r_id_ex.rs_val;
        w_ex_b = r_id_ex.rd_val;
        if (r_ex_mem.reg_write && (r_ex_mem.rd == r_id_ex.rs)) begin
            w_ex_a = w_mem_result;
        end else if (r_mem_wb.reg_write && (r_mem_wb.rd == r_id_ex.rs)) begin
            w_ex_a = r_mem_wb.wdata;
        end
        if (r_ex_mem.reg_write && (r_ex_mem.rd == r_id_ex.rd)) begin
            w_ex_b = w_mem_result;
        end else if (r_mem_wb.reg_write && (r_mem_wb.rd == r_id_ex.rd)) begin
            w_ex_b = r_mem_wb.wdata;
        end
    end

    pp_alu u_alu (
        .i_op (r_id_ex.alu_op),
        .i_a  (w_ex_a),
        .i_b  (w_ex_b),
        .o_y  (w_alu_y)
    );

    assign show = reset ? '0 : w_alu_y;

    // ---------------- MEM ----------------
    assign w_mem_result = r_ex_mem.mem_read ? r_dmem[r_ex_mem.alu_y[AddrW-1:0]]
                                            : r_ex_mem.alu_y;
    assign w_mem_write  = r_ex_mem.mem_write && !reset;
    assign mem_write    = w_mem_write;

    // Data memory write; suppressed while reset flushes the pipeline
    always_ff @(posedge clk) begin
        if (w_mem_write) begin
            r_dmem[r_ex_mem.alu_y[AddrW-1:0]] <= r_ex_mem.store_data;
        end
    end

    // ---------------- Pipeline registers ----------------
    // PC and stage registers; a stall freezes PC and IF/ID and bubbles EX
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= ResetPc;
            r_if_id  <= IfIdNop;
            r_id_ex  <= IdExNop;
            r_ex_mem <= ExMemNop;
            r_mem_wb <= MemWbNop;
        end else begin
            if (w_stall) begin
                r_id_ex <= IdExNop;
            end else begin
                r_pc          <= r_pc + 1'b1;
                r_if_id.instr <= instruction;
                r_id_ex       <= decode(w_id_op, w_id_rs, w_id_rd, w_id_rs_val, w_id_rd_val);
            end
            r_ex_mem.rd         <= r_id_ex.rd;
            r_ex_mem.alu_y      <= w_alu_y;
            r_ex_mem.store_data <= w_ex_a;
            r_ex_mem.reg_write  <= r_id_ex.reg_write;
            r_ex_mem.mem_write  <= r_id_ex.mem_write;
            r_ex_mem.mem_read   <= r_id_ex.mem_read;
            r_mem_wb.rd         <= r_ex_mem.rd;
            r_mem_wb.wdata      <= w_mem_result;
            r_mem_wb.reg_write  <= r_ex_mem.reg_write;
        end
    end

    // ---------------- WB ----------------
    // Register file: Rn resets to n, written from MEM/WB
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NumRegs; i++) begin
                r_regs[i] <= DataW'(i);
            end
        end else if (r_mem_wb.reg_write) begin
            r_regs[r_mem_wb.rd] <= r_mem_wb.wdata;
        end
    end

    assign result = r_regs[write_addr];

endmodule

// File: tb/tb_pipelined_processor.sv
// Directed tests for pipelined_processor: reset state, loader, basic program,
// forwarding, load-use stall, ALU wrap and mid-program reset.
module tb_pipelined_processor;

    logic        clk;
    logic        reset;
    logic [2:0]  write_addr;
    logic [15:0] result;
    logic        write_enable_fm;
    logic        rst_fm;
    logic [15:0] write_data_fm;
    logic [31:0] write_addr_fm;
    logic [15:0] instruction;
    logic        mem_write;
    logic [15:0] show;

    int total;
    int bad;

    localparam logic [4:0] TOpNot = 5'b00011;
    localparam logic [4:0] TOpAdd = 5'b11001;
    localparam logic [4:0] TOpStd = 5'b01100;
    localparam logic [4:0] TOpLdd = 5'b01101;

    pipelined_processor dut (
        .clk             (clk),
        .reset           (reset),
        .write_addr      (write_addr),
        .result          (result),
        .write_enable_fm (write_enable_fm),
        .rst_fm          (rst_fm),
        .write_data_fm   (write_data_fm),
        .write_addr_fm   (write_addr_fm),
        .instruction     (instruction),
        .mem_write       (mem_write),
        .show            (show)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] rs,
                                        input logic [2:0] rd);
        return {op, rs, rd, 5'b00000};
    endfunction

    // Advance one cycle, landing on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_word(input logic [31:0] addr, input logic [15:0] data);
        write_enable_fm = 1'b1;
        write_addr_fm   = addr;
        write_data_fm   = data;
        tick();
        write_enable_fm = 1'b0;
    endtask

    // Hold reset and fill the program area with NOPs
    task automatic start_program();
        reset = 1'b1;
        tick();
        for (int a = 32'h20; a < 32'h40; a++) begin
            load_word(32'(a), 16'h0000);
        end
    endtask

    task automatic test_reset();
        start_program();
        load_word(32'h20, 16'h1234);
        #1;
        if (instruction !== 16'h1234) begin
            $display("FAIL reset_instr got=%h want=%h", instruction, 16'h1234); bad++;
        end
        total++;
        if (mem_write !== 1'b0) begin
            $display("FAIL reset_mem_write got=%b want=0", mem_write); bad++;
        end
        total++;
        if (show !== 16'h0000) begin
            $display("FAIL reset_show got=%h want=0000", show); bad++;
        end
        total++;
        for (int r = 0; r < 8; r++) begin
            write_addr = 3'(r);
            #1;
            if (result !== 16'(r)) begin
                $display("FAIL reset_reg%0d got=%h want=%h", r, result, 16'(r)); bad++;
            end
            total++;
            tick();
        end
    endtask

    task automatic test_loader();
        rst_fm          = 1'b1;
        write_enable_fm = 1'b1;
        write_addr_fm   = 32'h20;
        write_data_fm   = 16'hBEEF;
        #1;
        if (instruction !== 16'h1234) begin
            $display("FAIL loader_blocked_now got=%h want=1234", instruction); bad++;
        end
        total++;
        tick();
        write_enable_fm = 1'b0;
        rst_fm          = 1'b0;
        #1;
        if (instruction !== 16'h1234) begin
            $display("FAIL loader_blocked_kept got=%h want=1234", instruction); bad++;
        end
        total++;
        write_enable_fm = 1'b1;
        write_addr_fm   = 32'h0000_0420;
        write_data_fm   = 16'h5A5A;
        #1;
        if (instruction !== 16'h5A5A) begin
            $display("FAIL loader_same_cycle got=%h want=5a5a", instruction); bad++;
        end
        total++;
        tick();
        write_enable_fm = 1'b0;
        #1;
        if (instruction !== 16'h5A5A) begin
            $display("FAIL loader_stored got=%h want=5a5a", instruction); bad++;
        end
        total++;
    endtask

    task automatic test_basic();
        int          mw_cnt;
        logic [15:0] show_e2;
        logic [15:0] show_e4;
        logic        mw_e4;
        start_program();
        load_word(32'h20, enc(TOpAdd, 3'd1, 3'd2));
        load_word(32'h21, enc(TOpStd, 3'd3, 3'd4));
        load_word(32'h22, enc(TOpNot, 3'd0, 3'd1));
        load_word(32'h23, enc(TOpLdd, 3'd4, 3'd5));
        reset   = 1'b0;
        mw_cnt  = 0;
        show_e2 = '0;
        show_e4 = '0;
        mw_e4   = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (mem_write === 1'b1) mw_cnt++;
            if (k == 2) show_e2 = show;
            if (k == 4) begin
                show_e4 = show;
                mw_e4   = mem_write;
            end
        end
        if (show_e2 !== 16'h0003) begin
            $display("FAIL basic_show_add got=%h want=0003", show_e2); bad++;
        end
        total++;
        if (show_e4 !== 16'hFFFE) begin
            $display("FAIL basic_show_not got=%h want=fffe", show_e4); bad++;
        end
        total++;
        if (mw_e4 !== 1'b1) begin
            $display("FAIL basic_mem_write_cycle got=%b want=1", mw_e4); bad++;
        end
        total++;
        if (mw_cnt != 1) begin
            $display("FAIL basic_mem_write_count got=%0d want=1", mw_cnt); bad++;
        end
        total++;
        write_addr = 3'd2;
        #1;
        if (result !== 16'h0003) begin
            $display("FAIL basic_r2 got=%h want=0003", result); bad++;
        end
        total++;
        write_addr = 3'd1;
        #1;
        if (result !== 16'hFFFE) begin
            $display("FAIL basic_r1 got=%h want=fffe", result); bad++;
        end
        total++;
        tick();
        write_addr = 3'd5;
        #1;
        if (result !== 16'h0003) begin
            $display("FAIL basic_m4_via_r5 got=%h want=0003", result); bad++;
        end
        total++;
    endtask

    task automatic test_forward();
        start_program();
        load_word(32'h20, enc(TOpAdd, 3'd1, 3'd2));
        load_word(32'h21, enc(TOpAdd, 3'd2, 3'd3));
        load_word(32'h22, 16'hF800);
        load_word(32'h23, 16'hF900);
        reset = 1'b0;
        tick();
        tick();
        if (show !== 16'h0003) begin
            $display("FAIL fwd_show_first got=%h want=0003", show); bad++;
        end
        total++;
        tick();
        if (show !== 16'h0006) begin
            $display("FAIL fwd_show_second got=%h want=0006", show); bad++;
        end
        total++;
        if (instruction !== 16'hF900) begin
            $display("FAIL fwd_no_stall_fetch got=%h want=f900", instruction); bad++;
        end
        total++;
        tick();
        tick();
        write_addr = 3'd3;
        #1;
        if (result !== 16'h0003) begin
            $display("FAIL fwd_r3_before_wb got=%h want=0003", result); bad++;
        end
        total++;
        tick();
        if (result !== 16'h0006) begin
            $display("FAIL fwd_r3 got=%h want=0006", result); bad++;
        end
        total++;
    endtask

    task automatic test_stall();
        start_program();
        load_word(32'h20, enc(TOpStd, 3'd1, 3'd2));
        load_word(32'h21, enc(TOpLdd, 3'd2, 3'd5));
        load_word(32'h22, enc(TOpAdd, 3'd5, 3'd6));
        load_word(32'h23, 16'hF800);
        load_word(32'h24, 16'hF900);
        reset = 1'b0;
        tick();
        tick();
        tick();
        if (instruction !== 16'hF800) begin
            $display("FAIL stall_fetch_pre got=%h want=f800", instruction); bad++;
        end
        total++;
        tick();
        if (show !== 16'h0000) begin
            $display("FAIL stall_bubble_show got=%h want=0000", show); bad++;
        end
        total++;
        if (instruction !== 16'hF800) begin
            $display("FAIL stall_fetch_held got=%h want=f800", instruction); bad++;
        end
        total++;
        tick();
        if (show !== 16'h0007) begin
            $display("FAIL stall_show_add got=%h want=0007", show); bad++;
        end
        total++;
        if (instruction !== 16'hF900) begin
            $display("FAIL stall_fetch_resume got=%h want=f900", instruction); bad++;
        end
        total++;
        tick();
        write_addr = 3'd5;
        #1;
        if (result !== 16'h0001) begin
            $display("FAIL stall_r5 got=%h want=0001", result); bad++;
        end
        total++;
        tick();
        write_addr = 3'd6;
        #1;
        if (result !== 16'h0006) begin
            $display("FAIL stall_r6_before_wb got=%h want=0006", result); bad++;
        end
        total++;
        tick();
        if (result !== 16'h0007) begin
            $display("FAIL stall_r6 got=%h want=0007", result); bad++;
        end
        total++;
    endtask

    task automatic test_alu();
        start_program();
        load_word(32'h20, enc(TOpNot, 3'd0, 3'd3));
        load_word(32'h21, enc(TOpAdd, 3'd7, 3'd7));
        load_word(32'h22, enc(TOpNot, 3'd0, 3'd0));
        load_word(32'h23, enc(TOpAdd, 3'd1, 3'd0));
        reset = 1'b0;
        tick();
        tick();
        if (show !== 16'hFFFC) begin
            $display("FAIL alu_show_not got=%h want=fffc", show); bad++;
        end
        total++;
        tick();
        if (show !== 16'h000E) begin
            $display("FAIL alu_show_add got=%h want=000e", show); bad++;
        end
        total++;
        tick();
        if (show !== 16'hFFFF) begin
            $display("FAIL alu_show_not0 got=%h want=ffff", show); bad++;
        end
        total++;
        tick();
        if (show !== 16'h0000) begin
            $display("FAIL alu_show_wrap got=%h want=0000", show); bad++;
        end
        total++;
        tick();
        tick();
        write_addr = 3'd3;
        #1;
        if (result !== 16'hFFFC) begin
            $display("FAIL alu_r3 got=%h want=fffc", result); bad++;
        end
        total++;
        write_addr = 3'd7;
        #1;
        if (result !== 16'h000E) begin
            $display("FAIL alu_r7 got=%h want=000e", result); bad++;
        end
        total++;
        write_addr = 3'd0;
        #1;
        if (result !== 16'hFFFF) begin
            $display("FAIL alu_r0_not got=%h want=ffff", result); bad++;
        end
        total++;
        tick();
        if (result !== 16'h0000) begin
            $display("FAIL alu_r0_wrap got=%h want=0000", result); bad++;
        end
        total++;
    endtask

    // Relies on M[4]=3 left behind by test_basic
    task automatic test_reset_mid();
        int mw_cnt;
        start_program();
        load_word(32'h20, enc(TOpNot, 3'd0, 3'd7));
        load_word(32'h21, enc(TOpStd, 3'd1, 3'd2));
        load_word(32'h22, enc(TOpStd, 3'd7, 3'd4));
        load_word(32'h23, enc(TOpStd, 3'd5, 3'd6));
        reset = 1'b0;
        repeat (4) tick();
        if (mem_write !== 1'b1) begin
            $display("FAIL mid_first_std got=%b want=1", mem_write); bad++;
        end
        total++;
        tick();
        if (mem_write !== 1'b1) begin
            $display("FAIL mid_second_std got=%b want=1", mem_write); bad++;
        end
        total++;
        write_addr = 3'd7;
        #1;
        if (result !== 16'hFFF8) begin
            $display("FAIL mid_r7_not got=%h want=fff8", result); bad++;
        end
        total++;
        reset = 1'b1;
        #1;
        if (mem_write !== 1'b0) begin
            $display("FAIL mid_mem_write_in_reset got=%b want=0", mem_write); bad++;
        end
        total++;
        if (show !== 16'h0000) begin
            $display("FAIL mid_show_in_reset got=%h want=0000", show); bad++;
        end
        total++;
        mw_cnt = 0;
        for (int r = 0; r < 8; r++) begin
            tick();
            if (mem_write === 1'b1) mw_cnt++;
            write_addr = 3'(r);
            #1;
            if (result !== 16'(r)) begin
                $display("FAIL mid_reg%0d got=%h want=%h", r, result, 16'(r)); bad++;
            end
            total++;
        end
        load_word(32'h20, enc(TOpLdd, 3'd4, 3'd1));
        load_word(32'h21, 16'h0000);
        load_word(32'h22, 16'h0000);
        load_word(32'h23, 16'h0000);
        reset = 1'b0;
        #1;
        if (instruction !== enc(TOpLdd, 3'd4, 3'd1)) begin
            $display("FAIL mid_pc_restart got=%h want=%h", instruction,
                     enc(TOpLdd, 3'd4, 3'd1)); bad++;
        end
        total++;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (mem_write === 1'b1) mw_cnt++;
        end
        if (mw_cnt != 0) begin
            $display("FAIL mid_no_mem_write got=%0d want=0", mw_cnt); bad++;
        end
        total++;
        write_addr = 3'd1;
        #1;
        if (result !== 16'h0003) begin
            $display("FAIL mid_m4_untouched got=%h want=0003", result); bad++;
        end
        total++;
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        reset           = 1'b1;
        write_addr      = 3'd0;
        write_enable_fm = 1'b0;
        rst_fm          = 1'b0;
        write_data_fm   = 16'h0000;
        write_addr_fm   = 32'h0;
        test_reset();
        test_loader();
        test_basic();
        test_forward();
        test_stall();
        test_alu();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
